// File: rtl/cdb_arbiter_pkg.sv
// Shared out-of-order core types: ROB index and result widths and the CDB lane record.
// The ROB uses the same lane typedef, so changing a width here changes it on both sides.
package cdb_arbiter_pkg;
    localparam int ROB_IDX_W  = 4;
    localparam int CDB_DATA_W = 16;
    localparam int CDB_LANES  = 4;

    typedef struct packed {
        logic                  valid;
        logic [ROB_IDX_W-1:0]  index;
        logic [CDB_DATA_W-1:0] value;
    } cdb_lane_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-side handshake and CDB lane bus of the arbiter.
// The slave modport is the arbiter's view; master is the driver/ROB side.
interface cdb_arbiter_if #(
    parameter int NUM_REQ   = 8,
    parameter int NUM_LANES = 4,
    parameter int IDX_W     = 4,
    parameter int DATA_W    = 16
);
    logic                        flush;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*IDX_W-1:0]    req_index;
    logic [NUM_REQ*DATA_W-1:0]   req_value;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_LANES-1:0]        cdb_valid;
    logic [NUM_LANES*IDX_W-1:0]  cdb_index;
    logic [NUM_LANES*DATA_W-1:0] cdb_value;
    logic [2:0]                  grant_cnt;

    modport slave (
        input  flush, req_valid, req_index, req_value,
        output req_ready, cdb_valid, cdb_index, cdb_value, grant_cnt
    );

    modport master (
        output flush, req_valid, req_index, req_value,
        input  req_ready, cdb_valid, cdb_index, cdb_value, grant_cnt
    );
endinterface

// File: rtl/cdb_arbiter_pick.sv
// Purpose: round-robin pick of up to NUM_LANES requesters starting at ptr.
// Latency: purely combinational. Backpressure: none; unpicked requesters simply wait.
module rr_pick_n #(
    parameter int NUM_REQ   = 8,
    parameter int NUM_LANES = 4,
    parameter int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [PTR_W-1:0]                    ptr_i,
    output logic [NUM_REQ-1:0]                  grant_o,
    output logic [NUM_LANES-1:0]                lane_vld_o,
    output logic [NUM_LANES-1:0][PTR_W-1:0]     lane_id_o,
    output logic [PTR_W-1:0]                    last_o,
    output logic                                any_o
);
    // Operands never exceed 2*NUM_REQ-2, so one conditional subtract is a full modulo.
    function automatic logic [PTR_W-1:0] wrap(input int v);
        return (v >= NUM_REQ) ? PTR_W'(v - NUM_REQ) : PTR_W'(v);
    endfunction

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] mask;
    logic [PTR_W-1:0]   pos;
    logic               found;

    always_comb begin
        rot        = '0;
        grant_o    = '0;
        lane_vld_o = '0;
        lane_id_o  = '0;
        last_o     = ptr_i;
        pos        = '0;
        found      = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            rot[j] = req_i[wrap(int'(ptr_i) + j)];
        end
        mask = rot;
        for (int k = 0; k < NUM_LANES; k++) begin
            found = 1'b0;
            pos   = '0;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && mask[j]) begin
                    found = 1'b1;
                    pos   = PTR_W'(j);
                end
            end
            if (found) begin
                mask[pos]     = 1'b0;
                lane_vld_o[k] = 1'b1;
                lane_id_o[k]  = wrap(int'(ptr_i) + int'(pos));
                grant_o[lane_id_o[k]] = 1'b1;
                last_o        = lane_id_o[k];
            end
        end
        any_o = lane_vld_o[0];
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Purpose: share the ROB's CDB write lanes among NUM_REQ result ports, round-robin.
// Latency: grant is combinational, lane data registered one cycle. Backpressure: ungranted ports hold valid.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 8,
    parameter int NUM_LANES = CDB_LANES,
    parameter int IDX_W     = ROB_IDX_W,
    parameter int DATA_W    = CDB_DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    cdb_arbiter_if.slave    bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]                ptr_q, ptr_d;
    cdb_lane_t [NUM_LANES-1:0]       lane_q, lane_d;
    logic [2:0]                      cnt_q, cnt_d;

    logic [NUM_REQ-1:0]              grant;
    logic [NUM_LANES-1:0]            lane_vld;
    logic [NUM_LANES-1:0][PTR_W-1:0] lane_id;
    logic [PTR_W-1:0]                last_id;
    logic                            any_grant;
    logic                            gate;

    rr_pick_n #(
        .NUM_REQ   (NUM_REQ),
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_pick (
        .req_i      (bus.req_valid),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .lane_vld_o (lane_vld),
        .lane_id_o  (lane_id),
        .last_o     (last_id),
        .any_o      (any_grant)
    );

    // Reset and flush both suppress the handshake so requesters keep their results.
    assign gate          = rst | bus.flush;
    assign bus.req_ready = gate ? '0 : grant;

    always_comb begin
        lane_d = lane_q;
        cnt_d  = 3'd0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_d[k].valid = lane_vld[k] & ~gate;
            if (lane_d[k].valid) begin
                lane_d[k].index = bus.req_index[int'(lane_id[k])*IDX_W +: IDX_W];
                lane_d[k].value = bus.req_value[int'(lane_id[k])*DATA_W +: DATA_W];
                cnt_d           = cnt_d + 3'd1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (!gate && any_grant) begin
            ptr_d = (last_id == PTR_W'(NUM_REQ - 1)) ? '0 : last_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            lane_q <= '0;
            cnt_q  <= 3'd0;
        end else begin
            ptr_q  <= ptr_d;
            lane_q <= lane_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane_out
        assign bus.cdb_valid[k]                    = lane_q[k].valid;
        assign bus.cdb_index[k*IDX_W +: IDX_W]     = lane_q[k].index;
        assign bus.cdb_value[k*DATA_W +: DATA_W]   = lane_q[k].value;
    end
    assign bus.grant_cnt = cnt_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random stimulus for cdb_arbiter; lane outputs are scored against a queue of
// expectations built from a scan-order reference model when each cycle's requests are driven.
module tb_cdb_arbiter;
    localparam int NR = 8;
    localparam int NL = 4;
    localparam int IW = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(NR), .NUM_LANES(NL), .IDX_W(IW), .DATA_W(DW)) bus ();

    cdb_arbiter #(.NUM_REQ(NR), .NUM_LANES(NL), .IDX_W(IW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NL-1:0]          vld;
        logic [NL-1:0][IW-1:0]  idx;
        logic [NL-1:0][DW-1:0]  val;
        int                     cnt;
        bit                     zero;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_e;
    int          errors = 0;
    int          checks = 0;
    logic [IW-1:0] r_idx[NR];
    logic [DW-1:0] r_val[NR];
    int          mdl_ptr = 0;

    // One cycle: drive requests, then predict ready and the lanes for the next cycle.
    task automatic apply(input logic [NR-1:0] v, input logic fl, input logic rs,
                         output logic [NR-1:0] rdy);
        exp_t e;
        int   n;
        int   last;
        int   r;
        @(posedge clk);
        #2;
        rst           = rs;
        bus.flush     = fl;
        bus.req_valid = v;
        for (int i = 0; i < NR; i++) begin
            bus.req_index[i*IW +: IW] = r_idx[i];
            bus.req_value[i*DW +: DW] = r_val[i];
        end
        #1;
        rdy   = '0;
        e.vld = '0;
        e.idx = '0;
        e.val = '0;
        e.zero = rs;
        n     = 0;
        last  = -1;
        if (!rs && !fl) begin
            for (int j = 0; j < NR; j++) begin
                r = (mdl_ptr + j) % NR;
                if (v[r] && n < NL) begin
                    rdy[r]   = 1'b1;
                    e.vld[n] = 1'b1;
                    e.idx[n] = r_idx[r];
                    e.val[n] = r_val[r];
                    n++;
                    last = r;
                end
            end
        end
        e.cnt = n;
        if (rs) mdl_ptr = 0;
        else if (last >= 0) mdl_ptr = (last + 1) % NR;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            checks++;
            if (bus.cdb_valid !== m_e.vld) begin
                errors++;
                $display("FAIL sb_cdb_valid got=%b exp=%b t=%0t", bus.cdb_valid, m_e.vld, $time);
            end
            checks++;
            if (bus.grant_cnt !== 3'(m_e.cnt)) begin
                errors++;
                $display("FAIL sb_grant_cnt got=%0d exp=%0d t=%0t", bus.grant_cnt, m_e.cnt, $time);
            end
            for (int k = 0; k < NL; k++) begin
                if (m_e.vld[k] || m_e.zero) begin
                    checks++;
                    if (bus.cdb_index[k*IW +: IW] !== m_e.idx[k] ||
                        bus.cdb_value[k*DW +: DW] !== m_e.val[k]) begin
                        errors++;
                        $display("FAIL sb_lane%0d got=(%h,%h) exp=(%h,%h) t=%0t", k,
                                 bus.cdb_index[k*IW +: IW], bus.cdb_value[k*DW +: DW],
                                 m_e.idx[k], m_e.val[k], $time);
                    end
                end
            end
        end
    end

    // Two granted requesters carrying the same ROB index is a requester protocol error.
    always @(negedge clk) begin
        for (int a = 0; a < NR; a++) begin
            for (int b = a + 1; b < NR; b++) begin
                if (bus.req_valid[a] && bus.req_valid[b] && bus.req_ready[a] && bus.req_ready[b])
                    assert (bus.req_index[a*IW +: IW] != bus.req_index[b*IW +: IW])
                    else $error("duplicate ROB index granted to requesters %0d and %0d", a, b);
            end
        end
    end

    task automatic test_reset();
        logic [NR-1:0] rdy;
        apply('0, 1'b0, 1'b1, rdy);
        apply('1, 1'b0, 1'b1, rdy);
        checks++;
        if (bus.req_ready !== '0) begin
            errors++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready);
        end
        checks++;
        if (bus.cdb_valid !== '0 || bus.grant_cnt !== 3'd0 || bus.cdb_index !== '0 ||
            bus.cdb_value !== '0 || dut.ptr_q !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b c=%0d i=%h d=%h p=%0d exp all 0", bus.cdb_valid,
                     bus.grant_cnt, bus.cdb_index, bus.cdb_value, dut.ptr_q);
        end
    endtask

    task automatic test_single();
        logic [NR-1:0] rdy;
        r_idx[0] = 4'd5;
        r_val[0] = 16'hBEEF;
        apply(8'h01, 1'b0, 1'b0, rdy);
        checks++;
        if (bus.req_ready !== 8'h01) begin
            errors++; $display("FAIL single_ready got=%b exp=00000001", bus.req_ready);
        end
        apply(8'h00, 1'b0, 1'b0, rdy);
        checks++;
        if (bus.cdb_valid !== 4'b0001 || bus.cdb_index[3:0] !== 4'd5 ||
            bus.cdb_value[15:0] !== 16'hBEEF || bus.grant_cnt !== 3'd1) begin
            errors++;
            $display("FAIL single_lane0 got v=%b i=%h d=%h c=%0d exp v=0001 i=5 d=beef c=1",
                     bus.cdb_valid, bus.cdb_index[3:0], bus.cdb_value[15:0], bus.grant_cnt);
        end
        checks++;
        if (dut.ptr_q !== 3'd1) begin
            errors++; $display("FAIL single_ptr got=%0d exp=1", dut.ptr_q);
        end
    endtask

    task automatic test_all_valid();
        logic [NR-1:0] rdy;
        for (int i = 0; i < NR; i++) begin
            r_idx[i] = IW'(i);
            r_val[i] = 16'h1000 + DW'(i);
        end
        apply(8'h00, 1'b0, 1'b1, rdy);
        apply(8'hFF, 1'b0, 1'b0, rdy);
        checks++;
        if (bus.req_ready !== 8'h0F) begin
            errors++; $display("FAIL allv_c0_ready got=%b exp=00001111", bus.req_ready);
        end
        apply(8'hFF, 1'b0, 1'b0, rdy);
        checks++;
        if (bus.req_ready !== 8'hF0 || dut.ptr_q !== 3'd4) begin
            errors++;
            $display("FAIL allv_c1 got ready=%b ptr=%0d exp ready=11110000 ptr=4", bus.req_ready, dut.ptr_q);
        end
    endtask

    task automatic test_wrap();
        logic [NR-1:0] rdy;
        apply(8'h20, 1'b0, 1'b0, rdy);
        checks++;
        if (dut.ptr_q !== 3'd0) begin
            errors++; $display("FAIL wrap_ptr0 got=%0d exp=0", dut.ptr_q);
        end
        apply(8'b0100_0101, 1'b0, 1'b0, rdy);
        checks++;
        if (bus.req_ready !== 8'b0100_0101 || dut.ptr_q !== 3'd6) begin
            errors++;
            $display("FAIL wrap_grant got ready=%b ptr=%0d exp ready=01000101 ptr=6", bus.req_ready, dut.ptr_q);
        end
        apply(8'h00, 1'b0, 1'b0, rdy);
        checks++;
        if (bus.cdb_valid !== 4'b0111 || bus.cdb_index[11:0] !== 12'h206 ||
            bus.grant_cnt !== 3'd3 || dut.ptr_q !== 3'd3) begin
            errors++;
            $display("FAIL wrap_lanes got v=%b i=%h c=%0d p=%0d exp v=0111 i=206 c=3 p=3",
                     bus.cdb_valid, bus.cdb_index[11:0], bus.grant_cnt, dut.ptr_q);
        end
    endtask

    task automatic test_flush();
        logic [NR-1:0] rdy;
        apply(8'hFF, 1'b1, 1'b0, rdy);
        checks++;
        if (bus.req_ready !== 8'h00) begin
            errors++; $display("FAIL flush_ready got=%b exp=0", bus.req_ready);
        end
        apply(8'hFF, 1'b0, 1'b0, rdy);
        checks++;
        if (bus.cdb_valid !== 4'b0000 || bus.grant_cnt !== 3'd0 || dut.ptr_q !== 3'd3 ||
            bus.req_ready !== 8'h78) begin
            errors++;
            $display("FAIL flush_resume got v=%b c=%0d p=%0d r=%b exp v=0 c=0 p=3 r=01111000",
                     bus.cdb_valid, bus.grant_cnt, dut.ptr_q, bus.req_ready);
        end
        apply(8'h00, 1'b0, 1'b0, rdy);
    endtask

    task automatic test_mid_reset();
        logic [NR-1:0] rdy;
        apply(8'h3F, 1'b0, 1'b0, rdy);
        apply(8'h3F, 1'b0, 1'b1, rdy);
        checks++;
        if (bus.req_ready !== 8'h00) begin
            errors++; $display("FAIL midrst_ready got=%b exp=0", bus.req_ready);
        end
        apply(8'h3F, 1'b0, 1'b0, rdy);
        checks++;
        if (bus.cdb_valid !== '0 || bus.cdb_index !== '0 || bus.cdb_value !== '0 ||
            bus.grant_cnt !== 3'd0 || dut.ptr_q !== 3'd0 || bus.req_ready !== 8'h0F) begin
            errors++;
            $display("FAIL midrst_after got v=%b i=%h d=%h c=%0d p=%0d r=%b exp zeros r=00001111",
                     bus.cdb_valid, bus.cdb_index, bus.cdb_value, bus.grant_cnt, dut.ptr_q, bus.req_ready);
        end
        apply(8'h30, 1'b0, 1'b0, rdy);
        checks++;
        if (bus.req_ready !== 8'h30) begin
            errors++; $display("FAIL midrst_regrant got=%b exp=00110000", bus.req_ready);
        end
        apply(8'h00, 1'b0, 1'b0, rdy);
    endtask

    task automatic test_random();
        logic [NR-1:0] v;
        logic [NR-1:0] rdy;
        int            wait_c[NR];
        v   = '0;
        rdy = '0;
        for (int i = 0; i < NR; i++) wait_c[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v[i] || rdy[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    if (v[i]) begin
                        r_idx[i] = {1'($urandom_range(0, 1)), 3'(i)};
                        r_val[i] = 16'($urandom);
                    end
                end
            end
            apply(v, 1'b0, 1'b0, rdy);
            checks++;
            if (bus.req_ready !== rdy) begin
                errors++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, rdy);
            end
            for (int i = 0; i < NR; i++) begin
                if (v[i] && !rdy[i]) begin
                    wait_c[i]++;
                    checks++;
                    if (wait_c[i] > 1) begin
                        errors++;
                        $display("FAIL rand_wait req=%0d waited=%0d limit=1 cyc=%0d", i, wait_c[i], c);
                    end
                end else begin
                    wait_c[i] = 0;
                end
            end
        end
        apply('0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        logic [NR-1:0] rdy;
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.req_index = '0;
        bus.req_value = '0;
        for (int i = 0; i < NR; i++) begin
            r_idx[i] = '0;
            r_val[i] = '0;
        end
        test_reset();
        test_single();
        test_all_valid();
        test_wrap();
        test_flush();
        test_mid_reset();
        test_random();
        apply('0, 1'b0, 1'b0, rdy);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
